// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder/subtractor.
package pipe_adder_pkg;
  typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational W-bit full-adder slice; one per pipeline stage.
module pipe_adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor: stage k adds slice k, operands and partial
// sums ride along in skew registers; a full output stall freezes every stage.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);
  localparam int SW = WIDTH / STAGES;

  logic                          adv;
  logic [WIDTH-1:0]              b_eff;
  logic                          c_eff;
  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][WIDTH-1:0]    a_q, b_q, sum_q;
  logic [STAGES:1]               c_q;
  logic [STAGES-1:0][SW-1:0]     s_sum;
  logic [STAGES-1:0]             s_co;

  // Subtract as a + ~b + ~borrow; b_q keeps the inverted B for overflow
  assign b_eff   = (sub_i == MODE_SUB) ? ~b_i : b_i;
  assign c_eff   = (sub_i == MODE_SUB) ? ~carry_i : carry_i;

  assign valid_o = vld_pipe[STAGES];
  assign adv     = !(valid_o && !ready_i);
  assign ready_o = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      pipe_adder_slice #(.W(SW)) u_slice (
        .a(a_i[SW-1:0]), .b(b_eff[SW-1:0]), .cin(c_eff),
        .sum(s_sum[k]), .cout(s_co[k])
      );
    end else begin : g_rest
      pipe_adder_slice #(.W(SW)) u_slice (
        .a(a_q[k][k*SW +: SW]), .b(b_q[k][k*SW +: SW]), .cin(c_q[k]),
        .sum(s_sum[k]), .cout(s_co[k])
      );
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      c_q      <= '0;
    end else if (adv) begin
      vld_pipe[1]          <= valid_i;
      a_q[1]               <= a_i;
      b_q[1]               <= b_eff;
      sum_q[1]             <= '0;
      sum_q[1][SW-1:0]     <= s_sum[0];
      c_q[1]               <= s_co[0];
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k]                  <= vld_pipe[k-1];
        a_q[k]                       <= a_q[k-1];
        b_q[k]                       <= b_q[k-1];
        sum_q[k]                     <= sum_q[k-1];
        sum_q[k][(k-1)*SW +: SW]     <= s_sum[k-1];
        c_q[k]                       <= s_co[k-1];
      end
    end
  end

  assign sum_o      = sum_q[STAGES];
  assign carry_o    = c_q[STAGES];
  assign overflow_o = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1]) &&
                      (sum_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: driver pushes model results, monitor pops on output transfer.
module tb_pipe_adder;
  import pipe_adder_pkg::*;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i, valid_i, ready_o, carry_i, sub_i, valid_o, ready_i, carry_o, overflow_o;
  logic [WIDTH-1:0] a_i, b_i, sum_o;

  int   errors = 0, checks = 0, n_acc = 0, n_pop = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
    .carry_o(carry_o), .overflow_o(overflow_o)
  );

  // Reference: true integer arithmetic; signed overflow = result outside W-bit signed range
  function automatic exp_t model(input logic [WIDTH-1:0] a, b, input logic c, s);
    logic [WIDTH+1:0] ua, ub, uc, sa, sb, r;
    exp_t e;
    ua = {2'b00, a};
    ub = {2'b00, b};
    uc = {{(WIDTH+1){1'b0}}, c};
    sa = {{2{a[WIDTH-1]}}, a};
    sb = {{2{b[WIDTH-1]}}, b};
    if (!s) begin
      r = ua + ub + uc; e.sum = r[WIDTH-1:0]; e.c = r[WIDTH];
      r = sa + sb + uc;
    end else begin
      r = ua - ub - uc; e.sum = r[WIDTH-1:0]; e.c = (ua >= ub + uc);
      r = sa - sb - uc;
    end
    e.v = !((r[WIDTH+1:WIDTH-1] == 3'b000) || (r[WIDTH+1:WIDTH-1] == 3'b111));
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [WIDTH-1:0] w;
    w = '0;
    case ($urandom_range(0, 5))
      0: w = '1;
      1: w = '0;
      2: w = {1'b0, {(WIDTH-1){1'b1}}};
      3: w = {1'b1, {(WIDTH-1){1'b0}}};
      default: for (int i = 0; i < WIDTH; i++) w[i] = 1'($urandom_range(0, 1));
    endcase
    return w;
  endfunction

  task automatic check_res(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sum=%h c=%b v=%b, required sum=%h c=%b v=%b",
               name, act.sum, act.c, act.v, exp.sum, exp.c, exp.v);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; pushes the expected result when the beat is taken
  task automatic drive(input logic v, input logic [WIDTH-1:0] a, b, input logic c, s,
                       input logic rdy, input logic use_e, input exp_t e, output bit acc);
    @(negedge clk);
    valid_i = v; a_i = a; b_i = b; carry_i = c; sub_i = s; ready_i = rdy;
    #1;
    acc = v && ready_o && !rst_i;
    if (acc) begin
      sb_q.push_back(use_e ? e : model(a, b, c, s));
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
  endtask

  task automatic send_dir(input logic [WIDTH-1:0] a, b, input logic c, s, input exp_t e);
    bit acc;
    int tries = 0;
    do begin
      drive(1'b1, a, b, c, s, 1'b1, 1'b1, e, acc);
      tries++;
    end while (!acc && tries < 20);
    if (!acc) check_int("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 200) begin idle(1); n++; end
    idle(2);
    check_int("drain_empty", sb_q.size(), 0);
  endtask

  // Monitor: in-order compare on every output transfer, plus hold check under stall
  initial begin
    exp_t e, held;
    bit   stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_int("stall_valid_hold", int'(valid_o), 1);
          check_res("stall_data_hold", {sum_o, carry_o, overflow_o}, held);
        end
        if (valid_o && ready_i) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got sum=%h, required no output", sum_o);
          end else begin
            e = sb_q.pop_front();
            check_res("result", {sum_o, carry_o, overflow_o}, e);
            n_pop++;
          end
        end
        stall_prev = valid_o && !ready_i;
        held = {sum_o, carry_o, overflow_o};
      end
    end
  end

  initial begin
    bit   acc;
    int   n, j, stale;
    logic [WIDTH-1:0] ones, smax, smin, one;
    ones = '1; smax = {1'b0, {(WIDTH-1){1'b1}}}; smin = {1'b1, {(WIDTH-1){1'b0}}};
    one = {{(WIDTH-1){1'b0}}, 1'b1};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0;
    carry_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_int("ready_during_reset", int'(ready_o), 1);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_int("reset_valid", int'(valid_o), 0);
    check_res("reset_outputs", {sum_o, carry_o, overflow_o}, '0);
    check_int("reset_ready", int'(ready_o), 1);

    // Isolated beat: latency and unsigned wrap with carry-out
    send_dir(ones, one, 1'b0, MODE_ADD, '{sum: '0, c: 1'b1, v: 1'b0});
    n = 0;
    do begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
      n++;
    end while (!valid_o && n < 20);
    check_int("latency", n, STAGES);
    idle(2);

    send_dir(smax, one, 1'b0, MODE_ADD, '{sum: smin, c: 1'b0, v: 1'b1});
    send_dir({{(WIDTH-3){1'b0}}, 3'd5}, {{(WIDTH-3){1'b0}}, 3'd7}, 1'b0, MODE_SUB,
             '{sum: {{(WIDTH-1){1'b1}}, 1'b0}, c: 1'b0, v: 1'b0});
    send_dir(smin, one, 1'b0, MODE_SUB, '{sum: smax, c: 1'b1, v: 1'b1});
    send_dir(ones, ones, 1'b1, MODE_ADD, '{sum: ones, c: 1'b1, v: 1'b0});
    send_dir('0, '0, 1'b1, MODE_SUB, '{sum: ones, c: 1'b0, v: 1'b0});
    drain();

    // Back-pressure: 8 back-to-back beats, ready_i low in cycles 5..7
    j = 0;
    for (int i = 0; i < 10; i++) begin
      drive(j < 8, rnd_word(), rnd_word(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), !(i >= 5 && i <= 7), 1'b0, '0, acc);
      check_int($sformatf("bp_ready_c%0d", i), int'(ready_o),
                (i >= 5 && i <= 7 && i >= STAGES) ? 0 : 1);
      if (acc) j++;
    end
    n = 0;
    while (j < 8 && n < 40) begin
      drive(1'b1, rnd_word(), rnd_word(), 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
      if (acc) j++;
      n++;
    end
    check_int("bp_beats_sent", j, 8);
    drain();

    // Reset with beats in flight
    for (int i = 0; i < 3; i++)
      drive(1'b1, rnd_word(), rnd_word(), 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_int("midreset_valid", int'(valid_o), 0);
    stale = 0;
    for (int i = 0; i < STAGES + 4; i++) begin
      idle(1);
      if (valid_o) stale++;
    end
    check_int("midreset_stale", stale, 0);

    // Random traffic with random bubbles and back-pressure
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 4000; i++)
      drive(($urandom_range(0, 3) != 0), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0), 1'b0, '0, acc);
    drain();
    check_int("random_count", n_pop, n_acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
